// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes, FSM state types and sizing helper for the AXI4-Lite register bank
package axi4_lite_pkg;

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} t_wr_state;
  typedef enum logic {R_IDLE, R_DATA} t_rd_state;

  // Index width for n registers, never below one bit so a single-register bank still has a selector.
  function automatic int f_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regbank_wr_chan.sv
// rtl/axi4_lite_slave_regbank_wr_chan.sv - AW/W holding registers, commit detection and B-channel FSM
module axi4_lite_wr_chan
  import axi4_lite_pkg::*;
#(
  parameter int G_ADDR_WIDTH = 32,
  parameter int G_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [G_ADDR_WIDTH-1:0]   awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [G_DATA_WIDTH-1:0]   wdata,
  input  logic [G_DATA_WIDTH/8-1:0] wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  output logic                      commit,
  output logic [G_ADDR_WIDTH-1:0]   commit_addr,
  output logic [G_DATA_WIDTH-1:0]   commit_data,
  output logic [G_DATA_WIDTH/8-1:0] commit_strb,
  input  logic                      commit_err
);

  t_wr_state state, state_nxt;

  logic                      aw_full, w_full;
  logic [G_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [G_DATA_WIDTH-1:0]   w_data_q;
  logic [G_DATA_WIDTH/8-1:0] w_strb_q;
  logic                      aw_hs, w_hs;

  assign bvalid  = (state == W_RESP);
  assign awready = en & ~aw_full & ~bvalid;
  assign wready  = en & ~w_full & ~bvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // A beat handshaking this cycle counts as available, so same-cycle AW+W commit without being held.
  assign commit      = (state == W_IDLE) & (aw_full | aw_hs) & (w_full | w_hs);
  assign commit_addr = aw_full ? aw_addr_q : awaddr;
  assign commit_data = w_full ? w_data_q : wdata;
  assign commit_strb = w_full ? w_strb_q : wstrb;

  always_ff @(posedge clk) begin
    if (rst) state <= W_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE: if (commit) state_nxt = W_RESP;
      W_RESP: if (bready) state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= C_RESP_OKAY;
    end else if (commit) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bresp   <= commit_err ? C_RESP_SLVERR : C_RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regbank.sv
// rtl/axi4_lite_slave_regbank.sv - parametrised AXI4-Lite register bank with RO/RW registers, byte strobes and SLVERR
module axi4_lite_slave_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                  G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int                  G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int                  G_REG_NB               = 8,
  parameter logic [G_REG_NB-1:0] G_RO_MASK              = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 awvalid,
  output logic                                 awready,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]    awaddr,
  input  logic [2:0]                           awprot,
  input  logic                                 wvalid,
  output logic                                 wready,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]    wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]  wstrb,
  output logic                                 bvalid,
  input  logic                                 bready,
  output logic [1:0]                           bresp,
  input  logic                                 arvalid,
  output logic                                 arready,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]    araddr,
  input  logic [2:0]                           arprot,
  output logic                                 rvalid,
  input  logic                                 rready,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]    rdata,
  output logic [1:0]                           rresp,
  input  logic [G_REG_NB*G_AXI4_LITE_DATA_WIDTH-1:0] registers_in,
  output logic [G_REG_NB*G_AXI4_LITE_DATA_WIDTH-1:0] registers_out,
  output logic [G_REG_NB-1:0]                  reg_wr_pulse
);

  localparam int AW  = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DW  = G_AXI4_LITE_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int AIW = AW - LSB;
  localparam int IW  = f_idx_width(G_REG_NB);
  localparam logic [AIW-1:0] C_REG_NB = AIW'(G_REG_NB);

  logic          alive;
  logic [DW-1:0] regs   [G_REG_NB];
  logic [DW-1:0] reg_in [G_REG_NB];

  logic          commit, commit_err;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  logic [AIW-1:0] wr_fidx, rd_fidx;
  logic [IW-1:0]  wr_idx, rd_idx;
  logic           wr_in_range, wr_ok, rd_in_range, ar_hs;
  logic           unused_ok;

  t_rd_state r_state, r_state_nxt;

  // Ready outputs stay low during reset and for the first edge after it.
  always_ff @(posedge clk) begin
    if (rst) alive <= 1'b0;
    else     alive <= 1'b1;
  end

  axi4_lite_wr_chan #(
    .G_ADDR_WIDTH (AW),
    .G_DATA_WIDTH (DW)
  ) u_wr_chan (
    .clk         (clk),
    .rst         (rst),
    .en          (alive),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .commit      (commit),
    .commit_addr (c_addr),
    .commit_data (c_data),
    .commit_strb (c_strb),
    .commit_err  (commit_err)
  );

  assign wr_fidx     = c_addr[AW-1:LSB];
  assign wr_idx      = wr_fidx[IW-1:0];
  assign wr_in_range = (wr_fidx < C_REG_NB);
  assign wr_ok       = wr_in_range & ~G_RO_MASK[wr_idx];
  assign commit_err  = ~wr_ok;

  assign unused_ok = ^{awprot, arprot, c_addr[LSB-1:0], araddr[LSB-1:0]};

  for (genvar i = 0; i < G_REG_NB; i++) begin : g_slice
    assign reg_in[i] = registers_in[i*DW +: DW];
    assign registers_out[i*DW +: DW] = G_RO_MASK[i] ? '0 : regs[i];
  end

  // RO entries are never written because wr_ok excludes them, so they stay at reset zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < G_REG_NB; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && wr_ok) begin
        reg_wr_pulse[wr_idx] <= 1'b1;
        for (int k = 0; k < SW; k++) begin
          if (c_strb[k]) regs[wr_idx][k*8 +: 8] <= c_data[k*8 +: 8];
        end
      end
    end
  end

  assign rd_fidx     = araddr[AW-1:LSB];
  assign rd_idx      = rd_fidx[IW-1:0];
  assign rd_in_range = (rd_fidx < C_REG_NB);
  assign rvalid      = (r_state == R_DATA);
  assign arready     = alive & ~rvalid;
  assign ar_hs       = arvalid & arready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_nxt = R_DATA;
      R_DATA: if (rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Sampling regs here with <= gives the pre-write value when a write commits on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rresp <= C_RESP_OKAY;
    end else if (ar_hs) begin
      if (!rd_in_range) begin
        rdata <= '0;
        rresp <= C_RESP_SLVERR;
      end else begin
        rdata <= G_RO_MASK[rd_idx] ? reg_in[rd_idx] : regs[rd_idx];
        rresp <= C_RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// tb/tb_axi4_lite_slave_regbank.sv - scoreboard testbench for the AXI4-Lite register bank
module tb_axi4_lite_slave_regbank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 8;
  localparam logic [NB-1:0] RO = 8'h08;

  logic clk = 1'b0;
  logic rst;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NB*DW-1:0] registers_in, registers_out;
  logic [NB-1:0] reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [31:0] model [NB];
  int pulse_cnt [NB];

  always #5 clk = ~clk;

  axi4_lite_slave_regbank #(
    .G_AXI4_LITE_ADDR_WIDTH (AW),
    .G_AXI4_LITE_DATA_WIDTH (DW),
    .G_REG_NB               (NB),
    .G_RO_MASK              (RO)
  ) dut (
    .clk (clk), .rst (rst),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awprot (awprot),
    .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
    .bvalid (bvalid), .bready (bready), .bresp (bresp),
    .arvalid (arvalid), .arready (arready), .araddr (araddr), .arprot (arprot),
    .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp),
    .registers_in (registers_in), .registers_out (registers_out),
    .reg_wr_pulse (reg_wr_pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[31:2]);
    if (idx < NB && !RO[idx]) begin
      bq.push_back(2'b00);
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic push_read(input logic [31:0] addr);
    int idx;
    idx = int'(addr[31:2]);
    if (idx >= NB)   rq.push_back({2'b10, 32'h0});
    else if (RO[idx]) rq.push_back({2'b00, registers_in[idx*32 +: 32]});
    else              rq.push_back({2'b00, model[idx]});
  endtask

  task automatic wait_b();
    bit done = 0;
    bready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (bvalid) begin
        @(posedge clk); #1;
        bready = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      check("b_timeout", 1, 0);
      bready = 1'b0;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit af, wf;
    push_write(addr, data, strb);
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 30 && (awvalid || wvalid); c++) begin
      @(negedge clk);
      af = awvalid && awready;
      wf = wvalid && wready;
      @(posedge clk); #1;
      if (af) awvalid = 1'b0;
      if (wf) wvalid = 1'b0;
    end
    if (awvalid || wvalid) begin
      check("aw_w_timeout", 1, 0);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    wait_b();
  endtask

  task automatic rd(input logic [31:0] addr);
    bit af, done;
    push_read(addr);
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    for (int c = 0; c < 30 && arvalid; c++) begin
      @(negedge clk);
      af = arvalid && arready;
      @(posedge clk); #1;
      if (af) arvalid = 1'b0;
    end
    if (arvalid) begin
      check("ar_timeout", 1, 0);
      arvalid = 1'b0;
    end
    done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (rvalid) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) check("r_timeout", 1, 0);
  endtask

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NB; i++) s += pulse_cnt[i];
    return s;
  endfunction

  // Scoreboard side: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else check("rdata_rresp", {rresp, rdata}, rq.pop_front());
      end
      for (int i = 0; i < NB; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, pt;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < NB; i++) begin
      model[i] = '0;
      pulse_cnt[i] = 0;
      registers_in[i*32 +: 32] = 32'hA000_0000 | i;
    end
    registers_in[3*32 +: 32] = 32'h1234_5678;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_regout", |registers_out, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);

    p0 = pulse_cnt[1];
    wr(32'h04, 32'hDEAD_BEEF, 4'hF);
    rd(32'h04);
    check("t2_pulse", pulse_cnt[1] - p0, 1);
    check("t2_regout", registers_out[63:32], 32'hDEAD_BEEF);

    wr(32'h08, 32'h1122_3344, 4'hF);
    wr(32'h08, 32'hAABB_CCDD, 4'h5);
    rd(32'h08);
    check("t3_regout", registers_out[95:64], 32'h11BB_33DD);

    p0 = pulse_cnt[3];
    wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
    rd(32'h0C);
    check("t4_no_pulse", pulse_cnt[3] - p0, 0);
    check("t4_regout_ro", registers_out[127:96], 32'h0);

    pt = pulse_total();
    wr(32'h20, 32'h0000_0001, 4'hF);
    rd(32'h20);
    rd(32'hFFFF_FFFC);
    check("t5_no_pulse", pulse_total() - pt, 0);

    wr(32'h1C, 32'hCAFE_F00D, 4'hF);
    rd(32'h1C);
    p0 = pulse_cnt[0];
    wr(32'h00, 32'h1234_5678, 4'h0);
    rd(32'h00);
    check("zero_strb_pulse", pulse_cnt[0] - p0, 1);
    check("zero_strb_regout", registers_out[31:0], 32'h0);
    rd(32'h07);

    wr(32'h14, 32'h5555_0000, 4'hF);
    @(posedge clk); #1;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("t6_w_accept", wvalid && wready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_w_held", {awready, wready, bvalid}, 3'b100);
    push_read(32'h14);
    push_write(32'h14, 32'h0BAD_F00D, 4'hF);
    @(posedge clk); #1;
    awaddr = 32'h14; awvalid = 1'b1;
    araddr = 32'h14; arvalid = 1'b1;
    @(negedge clk);
    check("t6_aw_ar_accept", {awready, arready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_b_hold", {bvalid, bresp, awready, wready}, 5'b10000);
      @(posedge clk); #1;
    end
    wait_b();
    @(negedge clk);
    check("t6_awready_back", awready, 1);
    rd(32'h14);
    check("t6_regout", registers_out[191:160], 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    check("bq_empty", bq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
